// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the multi-channel PWM block
//
// Contents:
//   pwm_state_t  - two-state controller FSM encoding (IDLE, RUN)
//   MIN_PERIOD   - smallest effective period; smaller requests are clamped up to it
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_multi_ch_chan.sv
// rtl/pwm_multi_ch_chan.sv - one PWM channel: duty shadow, compare, level register, polarity
//
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   synchronous active-low reset
//   run          in   1 = update level from the shared counter, 0 = force level low
//   shadow_load  in   copy duty_stage into the duty shadow this cycle
//   duty_stage   in   staged duty value for this channel
//   cnt          in   shared period counter
//   invert       in   output polarity, applied after the level register
//   pwm_out      out  channel output
module pwm_chan #(
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          run,
    input  logic          shadow_load,
    input  logic [CW-1:0] duty_stage,
    input  logic [CW-1:0] cnt,
    input  logic          invert,
    output logic          pwm_out
);

    logic [CW-1:0] duty_sh;
    logic          lvl;

    // The shadow is written at the same edge that wraps the counter, so the
    // first compare against the new duty happens at cnt = 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            duty_sh <= '0;
            lvl     <= 1'b0;
        end else begin
            if (shadow_load) begin
                duty_sh <= duty_stage;
            end
            // Unsigned compare: duty 0 never goes high, duty >= period never
            // goes low, so neither extreme glitches at the wrap.
            lvl <= run && (cnt < duty_sh);
        end
    end

    // Polarity is combinational so it follows invert even while idle.
    assign pwm_out = lvl ^ invert;

endmodule

// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel PWM with shared counter and double-buffered period/duty
//
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   synchronous active-low reset
//   enable       in   1 = run counter and outputs, 0 = idle
//   period       in   requested period in clocks (0 and 1 behave as 2)
//   duty         in   requested high time, channel i at [i*CW +: CW]
//   invert       in   per-channel output polarity
//   load         in   single-cycle request to stage period and duty
//   load_done    out  pulse in the cycle the staged values move to the shadows
//   cycle_start  out  pulse in every running cycle with cnt = 0
//   pwm_out      out  channel outputs
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CW         = 20,
    parameter int DEF_PERIOD = 500000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [CW-1:0]     period,
    input  logic [NCH*CW-1:0] duty,
    input  logic [NCH-1:0]    invert,
    input  logic              load,
    output logic              load_done,
    output logic              cycle_start,
    output logic [NCH-1:0]    pwm_out
);

    localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] MIN_P = CW'(MIN_PERIOD);

    pwm_state_t        state;
    pwm_state_t        state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     period_sh;
    logic [CW-1:0]     stage_period;
    logic [NCH*CW-1:0] stage_duty;
    logic              pending;

    logic [CW-1:0]     eff_period;
    logic              terminal;
    logic              running;
    logic              advance;
    logic              shadow_load;
    logic              chan_run;

    assign eff_period = (period_sh < MIN_P) ? MIN_P : period_sh;
    // >= rather than == keeps the counter bounded even if it were ever
    // beyond the period; shadows only change at the wrap or while cnt = 0.
    assign terminal   = (cnt >= (eff_period - CW'(1)));
    assign running    = (state == RUN);
    // Dropping enable stops the counter and levels at the very next edge.
    assign advance    = running && enable;

    // Idle: apply a pending request immediately. Running: only at the
    // terminal count so a period is never cut short or stretched.
    assign shadow_load = pending && (!running || terminal);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cycle_start = running && (cnt == '0);
        load_done   = shadow_load;
        chan_run    = advance;
    end

    // Shared counter: held at 0 whenever not advancing so the first running
    // cycle always starts a fresh period.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= terminal ? '0 : cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Staging and period shadow. A load in the same cycle as a shadow copy
    // lands in staging after the copy, so it waits for the next terminal
    // count and keeps pending set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            period_sh    <= DEF_P;
            stage_period <= DEF_P;
            stage_duty   <= '0;
            pending      <= 1'b0;
        end else begin
            if (shadow_load) begin
                period_sh <= stage_period;
                pending   <= 1'b0;
            end
            if (load) begin
                stage_period <= period;
                stage_duty   <= duty;
                pending      <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_chan #(
            .CW (CW)
        ) u_chan (
            .clk         (clk),
            .resetn      (resetn),
            .run         (chan_run),
            .shadow_load (shadow_load),
            .duty_stage  (stage_duty[i*CW +: CW]),
            .cnt         (cnt),
            .invert      (invert[i]),
            .pwm_out     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - self-checking bench for pwm_multi_ch
module tb_pwm_multi_ch;

    localparam int NCH        = 4;
    localparam int CW         = 8;
    localparam int DEF_PERIOD = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic              enable;
    logic [CW-1:0]     period;
    logic [NCH*CW-1:0] duty;
    logic [NCH-1:0]    invert;
    logic              load;
    logic              load_done;
    logic              cycle_start;
    logic [NCH-1:0]    pwm_out;

    typedef struct packed {
        logic [3:0] pwm;
        logic       cs;
        logic       ld;
    } exp_t;

    typedef struct {
        logic        rn;
        logic        en;
        logic        ld;
        logic [7:0]  per;
        logic [31:0] dv;
        logic [3:0]  inv;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] DV41  = {8'd200, 8'd8, 8'd3, 8'd0};
    localparam logic [31:0] DVA   = {8'd10, 8'd0, 8'd5, 8'd0};
    localparam logic [31:0] DVA2  = {8'd10, 8'd0, 8'd2, 8'd0};
    localparam logic [31:0] DV43A = {8'd10, 8'd0, 8'd7, 8'd0};
    localparam logic [31:0] DV43B = {8'd10, 8'd0, 8'd1, 8'd0};
    localparam logic [31:0] DV24  = {8'd10, 8'd0, 8'd6, 8'd0};
    localparam logic [31:0] DVC   = {8'd255, 8'd0, 8'd1, 8'd0};

    pwm_multi_ch #(
        .NCH        (NCH),
        .CW         (CW),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .period      (period),
        .duty        (duty),
        .invert      (invert),
        .load        (load),
        .load_done   (load_done),
        .cycle_start (cycle_start),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after a rising edge, sample the outputs
    // mid-cycle, then move to just after the next rising edge.
    task automatic cyc(input logic rn, input logic en, input logic ld,
                       input logic [7:0] per, input logic [31:0] dv,
                       input logic [3:0] inv, input logic chk, input exp_t e,
                       input string tag, input int j);
        exp_t x;
        resetn = rn;
        enable = en;
        load   = ld;
        period = per;
        duty   = dv;
        invert = inv;
        if (chk) sb.push_back(e);
        #2;
        if (chk) begin
            checks += 1;
            if (sb.size() == 0) begin
                failures += 1;
                $display("FAIL %s j=%0d scoreboard empty", tag, j);
            end else begin
                x = sb.pop_front();
                checks += 2;
                if (pwm_out !== x.pwm) begin
                    failures += 1;
                    $display("FAIL %s j=%0d pwm_out got=%b exp=%b", tag, j, pwm_out, x.pwm);
                end
                if (cycle_start !== x.cs) begin
                    failures += 1;
                    $display("FAIL %s j=%0d cycle_start got=%b exp=%b", tag, j, cycle_start, x.cs);
                end
                if (load_done !== x.ld) begin
                    failures += 1;
                    $display("FAIL %s j=%0d load_done got=%b exp=%b", tag, j, load_done, x.ld);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int k);
        cyc(vecs[k].rn, vecs[k].en, vecs[k].ld, vecs[k].per, vecs[k].dv,
            vecs[k].inv, 1'b1, vecs[k].e, "table", k);
    endtask

    // Start from IDLE with enable for n cycles, then drop enable and check one
    // idle cycle. Up to two loads (at j=la, j=lb) carry the same period p;
    // the latest one is expected at the first terminal count strictly after it.
    task automatic run_seq(input int n, input int p, input logic [31:0] d_old,
                           input logic [3:0] inv, input int la, input logic [31:0] dva,
                           input int lb, input logic [31:0] dvb, input string tag);
        int          last;
        int          japply;
        logic [31:0] dnew;
        logic [31:0] d;
        logic [7:0]  per8;
        exp_t        e;
        japply = -1;
        last   = (lb >= 0) ? lb : la;
        dnew   = (lb >= 0) ? dvb : dva;
        per8   = p[7:0];
        if (last >= 0) begin
            for (int j = last + 1; j <= n + p; j++) begin
                if (japply < 0 && ((j - 1) % p) == p - 1) japply = j;
            end
        end
        for (int j = 0; j <= n; j++) begin
            d = (japply >= 0 && (j - 1) > japply) ? dnew : d_old;
            for (int i = 0; i < 4; i++) begin
                e.pwm[i] = inv[i] ^ ((j >= 2) && (((j - 2) % p) < int'(d[i*8 +: 8])));
            end
            e.cs = (j >= 1) && (((j - 1) % p) == 0);
            e.ld = (j == japply);
            cyc(1'b1, (j < n), (j == la) || (j == lb), per8,
                (j == lb) ? dvb : dva, inv, 1'b1, e, tag, j);
        end
        e.pwm = inv;
        e.cs  = 1'b0;
        e.ld  = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, per8, 32'h0, inv, 1'b1, e, tag, n + 1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0000, '{4'b0000, 1'b0, 1'b0}};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'd3,  32'hffffffff, 4'b0000, '{4'b0000, 1'b0, 1'b0}};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0101, '{4'b0101, 1'b0, 1'b0}};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b1111, '{4'b1111, 1'b0, 1'b0}};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'd8,  DV41,         4'b0000, '{4'b0000, 1'b0, 1'b0}};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0000, '{4'b0000, 1'b0, 1'b1}};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0000, '{4'b0000, 1'b0, 1'b0}};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'd10, DVA,          4'b0000, '{4'b0000, 1'b0, 1'b0}};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0000, '{4'b0000, 1'b0, 1'b1}};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0000, '{4'b0000, 1'b0, 1'b0}};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd1,  DVC,          4'b0000, '{4'b0000, 1'b0, 1'b0}};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0000, '{4'b0000, 1'b0, 1'b1}};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        4'b0000, '{4'b0000, 1'b0, 1'b0}};

        resetn = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        period = '0;
        duty   = '0;
        invert = '0;
        @(posedge clk);
        #1;

        for (int k = 0; k <= 2; k++) apply_vec(k);
        run_seq(25, 10, 32'h0, 4'b0000, -1, 32'h0, -1, 32'h0, "default_period");

        for (int k = 3; k <= 6; k++) apply_vec(k);
        run_seq(20, 8, DV41, 4'b0000, -1, 32'h0, -1, 32'h0, "idle_load_run");
        run_seq(11, 8, DV41, 4'b0101, -1, 32'h0, -1, 32'h0, "invert_run");

        for (int k = 7; k <= 9; k++) apply_vec(k);
        run_seq(25, 10, DVA,   4'b0000, 5,  DVA2,  -1, 32'h0, "load_mid_period");
        run_seq(25, 10, DVA2,  4'b0000, 3,  DV43A, 7,  DV43B, "double_load");
        run_seq(35, 10, DV43B, 4'b0000, 10, DV24,  -1, 32'h0, "load_at_terminal");

        for (int k = 10; k <= 12; k++) apply_vec(k);
        run_seq(9, 2, DVC, 4'b0000, -1, 32'h0, -1, 32'h0, "period_clamp");

        // Reset mid-period with a load pending: the load must be discarded and
        // all shadows return to their defaults.
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b1, '{4'b0000, 1'b0, 1'b0}, "mid_reset", 0);
        cyc(1'b1, 1'b1, 1'b1, 8'd6, 32'hffffffff, 4'b0000, 1'b1, '{4'b0000, 1'b1, 1'b0}, "mid_reset", 1);
        cyc(1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b0, '{4'b0000, 1'b0, 1'b0}, "mid_reset", 2);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b1, '{4'b0000, 1'b0, 1'b0}, "mid_reset", 3);
        run_seq(15, 10, 32'h0, 4'b0000, -1, 32'h0, -1, 32'h0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
